uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of each requester's byte and of tx_data.
REQ-002 Parameter: NREQ, 4, number of requesters sharing the TX engine; fixed at 4 in this revision.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 Port: req  in  NREQ  per-requester transmit request; held high until the matching ack.
REQ-006 Port: req_data  in  NREQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W].
REQ-007 Port: tx_rdy  in  1  TX engine ready flag; 1 = idle and able to load.
REQ-008 Port: tx_load  out  1  one-cycle load strobe to the TX engine.
REQ-009 Port: tx_data  out  DATA_W  byte presented to the TX engine; valid while tx_load=1.
REQ-010 Port: ack  out  NREQ  one-cycle pulse to the granted requester, coincident with tx_load.
REQ-011 Port: done  out  NREQ  one-cycle pulse to the owning requester when its byte finishes.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: owner  out  2  index of the current or last granted requester.

Function
REQ-014 Encode the FSM as exactly four states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: when tx_rdy=1 and req!=0, select the winner, latch its byte and index, then go to LOAD.
REQ-016 IDLE with req=0, or with tx_rdy=0: remain in IDLE and assert no outputs.
REQ-017 LOAD: hold tx_load=1 and ack[owner]=1 for exactly one cycle, drive tx_data with the latched byte, then go to WAIT_BUSY.
REQ-018 Latency: tx_load rises 1 cycle after the IDLE cycle that sees tx_rdy=1 and a request.
REQ-019 WAIT_BUSY: stay until tx_rdy=0, then go to WAIT_DONE.
REQ-020 WAIT_DONE: stay until tx_rdy=1, then pulse done[owner] for one cycle and go to IDLE.
REQ-021 The first possible next tx_load is 2 cycles after the done pulse, because IDLE re-arbitrates.
REQ-022 Round-robin mode: start the search at pointer rr_ptr and choose the first requester with req set, in increasing index order modulo NREQ.
REQ-023 Update rr_ptr to (winner+1) mod NREQ in the LOAD cycle; wrap from 3 to 0.
REQ-024 Sample tx_data at selection; later changes to req_data do not affect the in-flight byte.
REQ-025 A req deasserted after selection does not cancel the transfer, and ack is still issued.
REQ-026 Assert at most one bit of ack and at most one bit of done in any cycle.
REQ-027 Hold tx_data at its last value outside LOAD.

Reset
REQ-028 While reset=0: state=IDLE, rr_ptr=0, owner=0, tx_data=0, and tx_load, ack, done and busy all 0.
REQ-029 Reset asserted mid-transfer aborts the transfer immediately; no done pulse is issued for it.
REQ-030 After reset deasserts, the first arbitration starts from requester 0.

Configuration
REQ-031 Macro UART_TX_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest index with req set wins and rr_ptr is neither implemented nor updated.
REQ-032 UART_TX_ARB_FIXED_PRIO_EN undefined: round-robin arbitration per REQ-022 and REQ-023.

Verification
REQ-033 Single request: tx_rdy=1, req=4'b0100, data2=8'hA5 -> cycle+1 tx_load=1, tx_data=8'hA5, ack=4'b0100, owner=2.
REQ-034 Completion: after load, drive tx_rdy 0 for 10 cycles then 1 -> done=4'b0100 for one cycle, busy=0 the next cycle.
REQ-035 Round-robin: req=4'b1111 held, engine completing each byte -> grant order 0,1,2,3,0; with FIXED_PRIO_EN -> 0,0,0.
REQ-036 Engine busy: req=4'b0001 with tx_rdy=0 for 5 cycles -> no tx_load and busy=0; tx_load fires 1 cycle after tx_rdy returns to 1.
REQ-037 Reset in WAIT_DONE: assert reset=0 -> all outputs 0 immediately; after release with req=4'b1000 -> owner=3, and the next grant with req=4'b1001 goes to 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX engine between NREQ requesters, one byte per grant.
// Latency: tx_load/ack one cycle after the IDLE cycle that sees tx_rdy=1 and a request; done when the engine returns ready.
// Backpressure: no grant while tx_rdy=0; requesters hold req until ack, no request is dropped.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.

module uart_tx_arbiter #(
   parameter int DATA_W = 8,
   parameter int NREQ   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] req_data,
   input  logic                   tx_rdy,
   output logic                   tx_load,
   output logic [DATA_W-1:0]      tx_data,
   output logic [NREQ-1:0]        ack,
   output logic [NREQ-1:0]        done,
   output logic                   busy,
   output logic [1:0]             owner
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;

   // Arbitration result for the current cycle; only consumed when IDLE accepts.
   logic                grant_vld;
   logic [1:0]          grant_idx;
   logic [DATA_W-1:0]   grant_dat;
   logic                sel;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
   logic [1:0]          rr_ptr;
   logic [1:0]          rr_cand;
`endif

`ifdef UART_TX_ARB_FIXED_PRIO_EN
   // Fixed priority: lowest requesting index wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_vld && req[i]) begin
            grant_vld = 1'b1;
            grant_idx = 2'(i);
         end
      end
   end
`else
   // Round-robin: scan upward from rr_ptr; the 2-bit add wraps 3 -> 0 for NREQ=4.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_cand   = '0;
      for (int i = 0; i < NREQ; i++) begin
         rr_cand = rr_ptr + 2'(i);
         if (!grant_vld && req[rr_cand]) begin
            grant_vld = 1'b1;
            grant_idx = rr_cand;
         end
      end
   end
`endif

   // Pick the winner's byte out of the packed request data bus.
   always_comb begin
      grant_dat = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == 2'(i)) begin
            grant_dat = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register; reset aborts any transfer in flight without a done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and strobes; done is issued in the WAIT_DONE cycle that sees the engine ready.
   always_comb begin
      state_nxt = state;
      tx_load   = 1'b0;
      ack       = '0;
      done      = '0;
      busy      = (state != IDLE);
      sel       = 1'b0;
      case (state)
         IDLE: begin
            if (tx_rdy && grant_vld) begin
               sel       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            tx_load    = 1'b1;
            ack[owner] = 1'b1;
            state_nxt  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!tx_rdy) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_rdy) begin
               done[owner] = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture winner index and byte at selection so later req/req_data changes cannot disturb the transfer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner   <= '0;
         tx_data <= '0;
      end else if (sel) begin
         owner   <= grant_idx;
         tx_data <= grant_dat;
      end
   end

`ifndef UART_TX_ARB_FIXED_PRIO_EN
   // Advance the round-robin pointer past the winner while its byte is being loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (state == LOAD) begin
         rr_ptr <= owner + 2'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a scoreboard of expected grants and done pulses.
// Stimulus pushes the expected grant/done, a separate monitor pops and compares on tx_load/done.
// Inputs are driven 1 time unit after the rising edge; the monitor samples on the falling edge.

module tb_uart_tx_arbiter;

   localparam int DATA_W = 8;
   localparam int NREQ   = 4;

   typedef struct packed {
      logic [1:0] own;
      logic [7:0] dat;
   } grant_t;

   logic                   clk;
   logic                   reset;
   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] req_data;
   logic                   tx_rdy;
   logic                   tx_load;
   logic [DATA_W-1:0]      tx_data;
   logic [NREQ-1:0]        ack;
   logic [NREQ-1:0]        done;
   logic                   busy;
   logic [1:0]             owner;

   grant_t     exp_grant[$];
   logic [3:0] exp_done[$];
   int         total = 0;
   int         bad   = 0;

   uart_tx_arbiter #(.DATA_W(DATA_W), .NREQ(NREQ)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .tx_rdy   (tx_rdy),
      .tx_load  (tx_load),
      .tx_data  (tx_data),
      .ack      (ack),
      .done     (done),
      .busy     (busy),
      .owner    (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_grant(input logic [1:0] own, input logic [7:0] dat);
      grant_t g;
      logic [3:0] oh;
      g.own = own;
      g.dat = dat;
      oh = '0;
      oh[own] = 1'b1;
      exp_grant.push_back(g);
      exp_done.push_back(oh);
   endtask

   // Tick until tx_load appears, bounded; n is the number of edges waited.
   task automatic wait_load(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!tx_load && n < 20);
      total++;
      if (!tx_load) begin
         bad++;
         $display("FAIL load_timeout: tx_load=%0b after %0d cycles, expected 1", tx_load, n);
      end
   endtask

   // Engine model: called in the LOAD cycle; goes busy for nbusy cycles, then returns ready.
   task automatic engine(input int nbusy);
      tx_rdy = 1'b0;
      repeat (nbusy) tick();
      tx_rdy = 1'b1;
      tick();
   endtask

   // Monitor: pop and compare whenever the DUT loads a byte or signals completion.
   initial begin
      grant_t     g;
      logic [3:0] oh;
      logic [3:0] d;
      forever begin
         @(negedge clk);
         if (tx_load) begin
            if (exp_grant.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_load: ack=%b tx_data=%h, expected no load", ack, tx_data);
            end else begin
               g = exp_grant.pop_front();
               oh = '0;
               oh[g.own] = 1'b1;
               check("grant_ack", 32'(ack), 32'(oh));
               check("grant_data", 32'(tx_data), 32'(g.dat));
               check("grant_owner", 32'(owner), 32'(g.own));
            end
         end
         if (done != '0) begin
            if (exp_done.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: done=%b, expected none", done);
            end else begin
               d = exp_done.pop_front();
               check("done_pulse", 32'(done), 32'(d));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [1:0] w;
      reset    = 1'b0;
      req      = '0;
      req_data = '0;
      tx_rdy   = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_tx_load", 32'(tx_load), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      reset = 1'b1;
      tick();

      // Single request for requester 2, byte A5, with req/data changed after selection
      req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      tx_rdy   = 1'b1;
      req      = 4'b0100;
      push_grant(2'd2, 8'hA5);
      tick();
      check("single_load_latency", 32'(tx_load), 32'd1);
      check("single_busy_load", 32'(busy), 32'd1);
      req = 4'b0000;
      req_data[23:16] = 8'h5A;
      tx_rdy = 1'b0;
      repeat (10) tick();
      check("single_busy_wait", 32'(busy), 32'd1);
      check("single_held_data", 32'(tx_data), 32'hA5);
      tx_rdy = 1'b1;
      tick();
      check("single_idle_busy", 32'(busy), 32'd0);
      check("single_idle_done", 32'(done), 32'd0);

      // Round-robin from a fresh reset with all four requesting
      reset = 1'b0;
      tick();
      reset = 1'b1;
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      tx_rdy = 1'b1;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
         w = 2'd0;
`else
         w = 2'(k % 4);
`endif
         push_grant(w, req_data[w*8 +: 8]);
         wait_load(n);
         check("rr_grant_gap", 32'(n), 32'd1);
         engine(2);
      end
      req = 4'b0000;

      // Engine not ready: no grant, no busy, until tx_rdy returns
      req = 4'b0001;
      tx_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("eng_busy_no_load", 32'(tx_load), 32'd0);
         check("eng_busy_idle", 32'(busy), 32'd0);
      end
      tx_rdy = 1'b1;
      push_grant(2'd0, 8'h11);
      tick();
      check("eng_ready_load", 32'(tx_load), 32'd1);
      req = 4'b0000;
      engine(3);

      // Reset in WAIT_DONE aborts without done
      req = 4'b0010;
      exp_grant.push_back('{own: 2'd1, dat: 8'h22});
      tick();
      req = 4'b0000;
      tx_rdy = 1'b0;
      tick();
      tick();
      check("wd_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("abort_tx_load", 32'(tx_load), 32'd0);
      check("abort_ack", 32'(ack), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_owner", 32'(owner), 32'd0);
      check("abort_tx_data", 32'(tx_data), 32'd0);
      tx_rdy = 1'b1;
      tick();
      check("abort_no_done", 32'(done), 32'd0);
      reset = 1'b1;
      req = 4'b1000;
      push_grant(2'd3, 8'h44);
      tick();
      check("post_rst_load", 32'(tx_load), 32'd1);
      check("post_rst_owner", 32'(owner), 32'd3);
      req = 4'b0000;
      engine(2);
      req = 4'b1001;
      push_grant(2'd0, 8'h11);
      wait_load(n);
      req = 4'b0000;
      engine(2);

      repeat (3) tick();
      check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
      check("done_queue_empty", 32'(exp_done.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
